xadc_scan_sequencer: RTL and testbench

- Downstream consumer of the on-board reset generator; first stage of the measurement datapath.
- Released from reset once the clock is locked and the reset pulse ends.
- On each XADC end-of-sequence (EOS) pulse, reads the 13 channel result registers over the XADC DRP port.
- Streams 12-bit samples, tagged with channel index, to the scaling/display logic.

---
 rtl/xadc_scan_sequencer.sv | 150 +++++++++++++++
 tb/tb_xadc_scan_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_scan_sequencer.sv
// xadc_scan_sequencer
// Reads the N_CH XADC conversion result registers over the DRP port after
// every end-of-sequence pulse and streams 12-bit samples tagged with their
// channel index to the scaling/display logic.
//
// Optional build macro XADC_SCAN_AVG_EN: accumulate four consecutive frames
// per channel and emit only the truncated mean on every fourth frame.
//
// DRP handshake: drp_den is a single-cycle request carrying drp_daddr; the
// matching drp_drdy strobe is accepted only while waiting for that read, and
// drp_do is captured in the same cycle drp_drdy is seen. drp_drdy outside the
// wait window is ignored. Output strobes (sample_valid, frame_done, overrun)
// are one cycle wide with no backpressure.
module xadc_scan_sequencer #(
  parameter int N_CH    = 13,
  parameter int TIMEOUT = 64
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        eos,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic        sample_valid,
  output logic [3:0]  sample_ch,
  output logic [11:0] sample_data,
  output logic        frame_done,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  localparam logic [3:0]    LAST_CH = 4'(N_CH - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [3:0]    ch;
  logic [TW-1:0] tcnt;
  logic [11:0]   data_q;
  logic [6:0]    daddr_q;
  logic          timeout_q;
  logic          in_store;
  logic          last_ch;
  logic          unused_do_lsbs;

  // ch0 is VP/VN at 7'h03; the auxiliary channels sit contiguously from 7'h10.
  function automatic logic [6:0] ch_addr(input logic [3:0] c);
    if (c == 4'd0) return 7'h03;
    return 7'h0F + {3'b000, c};
  endfunction

  assign in_store       = (state == S_STORE);
  assign last_ch        = (ch == LAST_CH);
  assign unused_do_lsbs = ^drp_do[3:0];

  // Scan FSM: one DRP read per channel, REQ -> WAIT -> STORE, back to IDLE after the last channel.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= S_IDLE;
      ch        <= 4'd0;
      tcnt      <= '0;
      data_q    <= 12'h000;
      daddr_q   <= 7'h00;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (eos) begin
            ch      <= 4'd0;
            daddr_q <= ch_addr(4'd0);
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (drp_drdy) begin
            data_q <= drp_do[15:4];
            state  <= S_STORE;
          end else if (tcnt == T_LAST) begin
            data_q    <= 12'h000;
            timeout_q <= 1'b1;
            state     <= S_STORE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          if (last_ch) begin
            state <= S_IDLE;
          end else begin
            ch      <= ch + 4'd1;
            daddr_q <= ch_addr(ch + 4'd1);
            state   <= S_REQ;
          end
        end
      endcase
    end
  end

  assign drp_den     = (state == S_REQ);
  assign drp_dwe     = 1'b0;
  assign drp_daddr   = daddr_q;
  assign sample_ch   = ch;
  assign timeout_err = timeout_q;
  // A new EOS can only be taken in IDLE; anywhere else it is reported and dropped.
  assign overrun     = eos && (state != S_IDLE) && !rst;

`ifdef XADC_SCAN_AVG_EN
  logic [13:0] acc [N_CH];
  logic [1:0]  fcnt;
  logic [13:0] acc_sum;
  logic        emit;
  logic [1:0]  unused_sum_lsbs;

  assign acc_sum         = acc[ch] + {2'b00, data_q};
  assign emit            = (fcnt == 2'd3);
  assign unused_sum_lsbs = acc_sum[1:0];

  // Per-channel running sums over four frames; cleared on the frame that emits them.
  always_ff @(posedge pclk) begin
    if (rst) begin
      fcnt <= 2'd0;
      for (int i = 0; i < N_CH; i++) acc[i] <= 14'h0000;
    end else if (in_store) begin
      acc[ch] <= emit ? 14'h0000 : acc_sum;
      if (last_ch) fcnt <= fcnt + 2'd1;
    end
  end

  assign sample_valid = in_store && emit;
  assign frame_done   = in_store && last_ch && emit;
  assign sample_data  = acc_sum[13:2];
`else
  assign sample_valid = in_store;
  assign frame_done   = in_store && last_ch;
  assign sample_data  = data_q;
`endif

endmodule

// File: tb/tb_xadc_scan_sequencer.sv
// tb_xadc_scan_sequencer
// Directed scenario sequence with randomized DRP data and response delays.
// An XADC responder answers DRP reads from a per-channel plan; a monitor logs
// every DRP request, sample, frame_done and overrun with its cycle number; the
// expected frame is derived from the plan (address map, data[15:4], timeout
// zero-fill, response delay + 1 latency) and compared through an expected queue.
module tb_xadc_scan_sequencer;

  localparam int N  = 13;
  localparam int TO = 64;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        eos = 1'b0;
  logic [15:0] drp_do = 16'h0000;
  logic        drp_drdy = 1'b0;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic        sample_valid;
  logic [3:0]  sample_ch;
  logic [11:0] sample_data;
  logic        frame_done;
  logic        overrun;
  logic        timeout_err;

  xadc_scan_sequencer #(.N_CH(N), .TIMEOUT(TO)) dut (
    .pclk(pclk), .rst(rst), .eos(eos), .drp_do(drp_do), .drp_drdy(drp_drdy),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // ---------------- XADC responder ----------------
  // delay_cfg[k] >= 1: drdy is high during the cycle that is delay_cfg[k]
  // cycles after the den cycle; delay_cfg[k] < 1: the read is never answered.
  int          delay_cfg [N];
  logic [15:0] data_cfg  [N];

  initial begin : responder
    int c;
    forever begin
      @(negedge pclk);
      if (drp_den === 1'b1) begin
        c = (drp_daddr == 7'h03) ? 0 : int'(drp_daddr) - 15;
        if (c >= 0 && c < N && delay_cfg[c] >= 1) begin
          repeat (delay_cfg[c]) @(posedge pclk);
          #1;
          drp_drdy = 1'b1;
          drp_do   = data_cfg[c];
          @(posedge pclk);
          #1;
          drp_drdy = 1'b0;
          drp_do   = 16'($urandom);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [6:0]  den_addr_q [$];
  int          den_cyc_q  [$];
  logic [15:0] smp_q      [$];
  int          smp_cyc_q  [$];
  int          drdy_cyc_q [$];
  int          fd_cyc_q   [$];
  int          ov_cnt = 0;
  int          dwe_hi = 0;
  int          clr_gen = 0;
  int          seen_gen = 0;

  always @(negedge pclk) begin
    if (clr_gen != seen_gen) begin
      seen_gen = clr_gen;
      den_addr_q.delete(); den_cyc_q.delete(); smp_q.delete(); smp_cyc_q.delete();
      drdy_cyc_q.delete(); fd_cyc_q.delete(); ov_cnt = 0;
    end
    if (drp_den === 1'b1) begin den_addr_q.push_back(drp_daddr); den_cyc_q.push_back(cyc); end
    if (sample_valid === 1'b1) begin smp_q.push_back({sample_ch, sample_data}); smp_cyc_q.push_back(cyc); end
    if (drp_drdy === 1'b1) drdy_cyc_q.push_back(cyc);
    if (frame_done === 1'b1) fd_cyc_q.push_back(cyc);
    if (overrun === 1'b1) ov_cnt++;
    if (drp_dwe !== 1'b0) dwe_hi++;
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    clr_gen++;
    @(negedge pclk);
    #1;
  endtask

  task automatic pulse_eos();
    @(posedge pclk); #1; eos = 1'b1;
    @(posedge pclk); #1; eos = 1'b0;
  endtask

  task automatic wait_dens(input int n, input int budget);
    int k;
    k = 0;
    while (den_addr_q.size() < n && k < budget) begin @(negedge pclk); #1; k++; end
    check($sformatf("wait_den%0d", n), 32'(den_addr_q.size() >= n), 32'd1);
  endtask

  task automatic wait_drdys(input int n, input int budget);
    int k;
    k = 0;
    while (drdy_cyc_q.size() < n && k < budget) begin @(negedge pclk); #1; k++; end
    check($sformatf("wait_drdy%0d", n), 32'(drdy_cyc_q.size() >= n), 32'd1);
  endtask

  task automatic set_cfg(input int dmin, input int dmax);
    for (int k = 0; k < N; k++) begin
      delay_cfg[k] = $urandom_range(dmax, dmin);
      data_cfg[k]  = 16'($urandom);
    end
  endtask

  task automatic run_frame();
    clear_mon();
    pulse_eos();
    wait_dens(N, 3000);
    repeat (80) @(negedge pclk);
    #1;
  endtask

  // Expected raw frame built from the responder plan.
  task automatic check_frame(input string tag);
    logic [15:0] exp_q [$];
    logic [15:0] e;
    int          lat;
    exp_q = {};
    for (int k = 0; k < N; k++)
      exp_q.push_back({4'(k), (delay_cfg[k] >= 1) ? data_cfg[k][15:4] : 12'h000});
    check({tag, "/den_count"}, 32'(den_addr_q.size()), 32'(N));
    check({tag, "/smp_count"}, 32'(smp_q.size()), 32'(N));
    check({tag, "/fd_count"}, 32'(fd_cyc_q.size()), 32'd1);
    for (int k = 0; k < N; k++) begin
      e = exp_q.pop_front();
      if (k < den_addr_q.size())
        check($sformatf("%s/addr%0d", tag, k), 32'(den_addr_q[k]), 32'((k == 0) ? 3 : 16 + k - 1));
      if (k < smp_q.size()) begin
        check($sformatf("%s/smp%0d", tag, k), 32'(smp_q[k]), 32'(e));
        lat = (delay_cfg[k] >= 1) ? delay_cfg[k] + 1 : TO + 1;
        if (k < den_cyc_q.size())
          check($sformatf("%s/lat%0d", tag, k), 32'(smp_cyc_q[k] - den_cyc_q[k]), 32'(lat));
      end
    end
    if (fd_cyc_q.size() >= 1 && smp_cyc_q.size() >= N)
      check({tag, "/fd_cycle"}, 32'(fd_cyc_q[0]), 32'(smp_cyc_q[N-1]));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int acc_m [N];
    int ch0_vals [4];

    for (int k = 0; k < N; k++) begin delay_cfg[k] = 2; data_cfg[k] = 16'hABC0; acc_m[k] = 0; end
    ch0_vals = '{100, 200, 300, 401};

    // reset for 5 cycles; outputs checked while reset is held
    rst = 1'b1;
    repeat (5) @(posedge pclk);
    @(negedge pclk);
    check("rst/den", 32'(drp_den), 32'd0);
    check("rst/dwe", 32'(drp_dwe), 32'd0);
    check("rst/daddr", 32'(drp_daddr), 32'h00);
    check("rst/valid", 32'(sample_valid), 32'd0);
    check("rst/ch", 32'(sample_ch), 32'd0);
    check("rst/data", 32'(sample_data), 32'd0);
    check("rst/fd", 32'(frame_done), 32'd0);
    check("rst/ov", 32'(overrun), 32'd0);
    check("rst/tmo", 32'(timeout_err), 32'd0);
    @(posedge pclk); #1; rst = 1'b0;
    repeat (3) @(posedge pclk);

`ifdef XADC_SCAN_AVG_EN
    for (int f = 0; f < 4; f++) begin
      set_cfg(1, 4);
      data_cfg[0] = 16'(ch0_vals[f] << 4) | 16'($urandom_range(15, 0));
      for (int k = 0; k < N; k++) acc_m[k] += int'(data_cfg[k][15:4]);
      run_frame();
      check($sformatf("avg%0d/den_count", f), 32'(den_addr_q.size()), 32'(N));
      if (f < 3) begin
        check($sformatf("avg%0d/smp_count", f), 32'(smp_q.size()), 32'd0);
        check($sformatf("avg%0d/fd_count", f), 32'(fd_cyc_q.size()), 32'd0);
      end else begin
        check("avg3/smp_count", 32'(smp_q.size()), 32'(N));
        check("avg3/fd_count", 32'(fd_cyc_q.size()), 32'd1);
        for (int k = 0; k < N; k++)
          if (k < smp_q.size())
            check($sformatf("avg3/smp%0d", k), 32'(smp_q[k]), 32'({4'(k), 12'(acc_m[k] / 4)}));
        if (smp_q.size() >= 1) check("avg3/ch0_250", 32'(smp_q[0][11:0]), 32'd250);
      end
    end
`else
    // fixed-data frame, drdy 2 cycles after each den
    for (int k = 0; k < N; k++) begin delay_cfg[k] = 2; data_cfg[k] = 16'hABC0; end
    run_frame();
    check_frame("fixed");
    check("fixed/ov", 32'(ov_cnt), 32'd0);
    check("fixed/tmo", 32'(timeout_err), 32'd0);

    // randomized data and response delays
    for (int r = 0; r < 2; r++) begin
      set_cfg(1, 6);
      run_frame();
      check_frame($sformatf("rand%0d", r));
      check($sformatf("rand%0d/ov", r), 32'(ov_cnt), 32'd0);
    end

    // second eos during the ch5 read
    set_cfg(2, 2);
    clear_mon();
    pulse_eos();
    wait_dens(6, 500);
    @(posedge pclk); #1; eos = 1'b1;
    @(posedge pclk); #1; eos = 1'b0;
    wait_dens(N, 3000);
    repeat (80) @(negedge pclk);
    #1;
    check_frame("ovr_mid");
    check("ovr_mid/ov", 32'(ov_cnt), 32'd1);

    // eos coinciding with the final STORE: flagged, no restart
    set_cfg(1, 5);
    clear_mon();
    pulse_eos();
    wait_drdys(N, 3000);
    @(posedge pclk); #1; eos = 1'b1;
    @(posedge pclk); #1; eos = 1'b0;
    repeat (80) @(negedge pclk);
    #1;
    check_frame("ovr_last");
    check("ovr_last/ov", 32'(ov_cnt), 32'd1);

    // drdy withheld on ch3 -> zero sample after the timeout
    check("tmo/before", 32'(timeout_err), 32'd0);
    set_cfg(1, 4);
    delay_cfg[3] = 0;
    run_frame();
    check_frame("tmo");
    check("tmo/flag", 32'(timeout_err), 32'd1);
    set_cfg(1, 4);
    run_frame();
    check_frame("tmo_after");
    check("tmo/sticky", 32'(timeout_err), 32'd1);

    // reset during the ch7 wait, drdy arriving the cycle after reset
    set_cfg(2, 2);
    clear_mon();
    pulse_eos();
    wait_dens(8, 500);
    @(posedge pclk); #1; rst = 1'b1;
    @(posedge pclk); #1; rst = 1'b0;
    check("rstmid/den", 32'(drp_den), 32'd0);
    check("rstmid/tmo", 32'(timeout_err), 32'd0);
    repeat (80) @(negedge pclk);
    #1;
    check("rstmid/smp_count", 32'(smp_q.size()), 32'd7);
    check("rstmid/fd_count", 32'(fd_cyc_q.size()), 32'd0);
    check("rstmid/den_count", 32'(den_addr_q.size()), 32'd8);
    set_cfg(1, 6);
    run_frame();
    check_frame("after_rst");
`endif

    check("dwe_never", 32'(dwe_hi), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: observed=time_limit expected=finish");
    $fatal(1, "time limit");
  end

endmodule
